msg_stream_demux: RTL and testbench

- Receive end of the combined sample/message stream protocol that the stream combiner produces.
- Parses length-prefixed packets from one WDTH-bit stream and routes each payload word to one of N_STREAMS output channels.
- Output channels share a single data bus, with one valid strobe per channel.
- Sits at the input of a block chain, or on the host-facing side of a QA harness, so that the combined stream can be pulled apart back into per-stream samples and messages.

---
 rtl/msg_stream_demux_if.sv | 34 +++
 rtl/msg_stream_demux.sv | 105 ++++++++++
 tb/tb_msg_stream_demux.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/msg_stream_demux_if.sv
// Purpose: bundles the combined input stream and the routed per-channel outputs of the demux.
// Latency: none (wires only); timing is set by the modules on either side.
// Backpressure: none; in_nd is a pure valid strobe and the outputs are fire-and-forget strobes.
interface msg_stream_demux_if #(
    parameter int N_STREAMS = 2,
    parameter int WDTH      = 32
);
    logic [WDTH-1:0]      in_data;
    logic                 in_nd;
    logic [WDTH-1:0]      out_data;
    logic [N_STREAMS-1:0] out_nd;
    logic                 out_last;
    logic                 error;

    // Source of the combined stream and consumer of the routed channels
    modport master (
        output in_data,
        output in_nd,
        input  out_data,
        input  out_nd,
        input  out_last,
        input  error
    );

    // The demux itself
    modport slave (
        input  in_data,
        input  in_nd,
        output out_data,
        output out_nd,
        output out_last,
        output error
    );
endinterface

// File: rtl/msg_stream_demux.sv
// Purpose: parses length-prefixed packets from one combined stream and routes payload words to N_STREAMS channels.
// Latency: 1 cycle from an accepted payload word to its out_nd strobe; all outputs registered.
// Backpressure: none; every in_nd word is consumed, malformed headers pulse error and are dropped.
module msg_stream_demux #(
    parameter int N_STREAMS     = 2,
    parameter int LOG_N_STREAMS = 1,
    parameter int WDTH          = 32,
    parameter int LEN_WDTH      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    msg_stream_demux_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Single-bit seed for the one-hot channel strobe.
    localparam logic [N_STREAMS-1:0] CH_ONE = {{(N_STREAMS-1){1'b0}}, 1'b1};
    localparam logic [LEN_WDTH-1:0]  CNT_ONE = {{(LEN_WDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WDTH-1:0]  CNT_ZERO = '0;

    state_t                   state;
    logic [LEN_WDTH-1:0]      count;
    logic [LOG_N_STREAMS-1:0] id_q;

    logic                     hdr_flag;
    logic [LOG_N_STREAMS-1:0] hdr_id;
    logic [LEN_WDTH-1:0]      hdr_len;
    logic                     hdr_id_ok;
    logic                     last_word;

    // Header field extraction; only meaningful while the FSM expects a header.
    always_comb begin
        hdr_flag  = bus.in_data[WDTH-1];
        hdr_id    = bus.in_data[WDTH-2 -: LOG_N_STREAMS];
        hdr_len   = bus.in_data[LEN_WDTH-1:0];
        // The id field may encode more channels than exist; those are rejected.
        hdr_id_ok = (32'(hdr_id) < 32'(N_STREAMS));
        // Counter holds words still to come, so 1 means this word closes the packet.
        last_word = (count == CNT_ONE);
    end

    // Packet FSM with registered outputs; the strobes default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            id_q     <= '0;
            bus.out_data <= '0;
            bus.out_nd   <= '0;
            bus.out_last <= 1'b0;
            bus.error    <= 1'b0;
        end else begin
            bus.out_nd   <= '0;
            bus.out_last <= 1'b0;
            bus.error    <= 1'b0;
            if (bus.in_nd) begin
                case (state)
                    IDLE: begin
                        if (!hdr_flag) begin
                            // Stray payload-looking word with no packet open.
                            bus.error <= 1'b1;
                        end else if (hdr_len == CNT_ZERO) begin
                            // Empty packets are not legal on this stream.
                            bus.error <= 1'b1;
                        end else if (!hdr_id_ok) begin
                            // Unknown channel: flag once, then swallow its payload so
                            // framing stays aligned for the next header.
                            bus.error <= 1'b1;
                            count     <= hdr_len;
                            state     <= DISCARD;
                        end else begin
                            id_q  <= hdr_id;
                            count <= hdr_len;
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        bus.out_data <= bus.in_data;
                        bus.out_nd   <= CH_ONE << id_q;
                        count        <= count - CNT_ONE;
                        if (last_word) begin
                            bus.out_last <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    DISCARD: begin
                        count <= count - CNT_ONE;
                        if (last_word) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msg_stream_demux.sv
// Purpose: directed self-checking bench for msg_stream_demux (2-channel and 3-channel builds).
// Latency: expects each response one clock after the driving word.
// Backpressure: none exercised; the demux has no ready path.
module tb_msg_stream_demux;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [35:0] obs2;   // {out_nd[1:0], out_last, error, out_data}
    logic [36:0] obs3;   // {out_nd[2:0], out_last, error, out_data}

    msg_stream_demux_if #(.N_STREAMS(2), .WDTH(32)) b2 ();
    msg_stream_demux_if #(.N_STREAMS(3), .WDTH(32)) b3 ();

    msg_stream_demux #(.N_STREAMS(2), .LOG_N_STREAMS(1), .WDTH(32), .LEN_WDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    msg_stream_demux #(.N_STREAMS(3), .LOG_N_STREAMS(2), .WDTH(32), .LEN_WDTH(8)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one word into the 2-channel DUT and capture its registered response.
    task automatic step(input logic nd, input logic [31:0] w);
        @(negedge clk);
        b2.in_nd   = nd;
        b2.in_data = w;
        b3.in_nd   = 1'b0;
        @(posedge clk);
        #1;
        obs2 = {b2.out_nd, b2.out_last, b2.error, b2.out_data};
    endtask

    // Same for the 3-channel DUT.
    task automatic step3(input logic nd, input logic [31:0] w);
        @(negedge clk);
        b3.in_nd   = nd;
        b3.in_data = w;
        b2.in_nd   = 1'b0;
        @(posedge clk);
        #1;
        obs3 = {b3.out_nd, b3.out_last, b3.error, b3.out_data};
    endtask

    // error and out_nd must never coincide on either build.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            total++;
            if ((b2.error && |b2.out_nd) || (b3.error && |b3.out_nd)) begin
                bad++;
                $display("FAIL err_nd_overlap got b2=%b/%b b3=%b/%b want no overlap",
                         b2.error, b2.out_nd, b3.error, b3.out_nd);
            end
        end
    end

    task automatic test_reset();
        rst_n      = 1'b0;
        b2.in_nd   = 1'b0;
        b2.in_data = '0;
        b3.in_nd   = 1'b0;
        b3.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        obs2 = {b2.out_nd, b2.out_last, b2.error, b2.out_data};
        obs3 = {b3.out_nd, b3.out_last, b3.error, b3.out_data};
        total++;
        if (obs2 !== 36'h0) begin bad++; $display("FAIL reset_b2 got=%h want=%h", obs2, 36'h0); end
        total++;
        if (obs3 !== 37'h0) begin bad++; $display("FAIL reset_b3 got=%h want=%h", obs3, 37'h0); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        step(1'b1, 32'h8000_0002);
        total++;
        if (obs2 !== {2'b00, 1'b0, 1'b0, 32'h0}) begin bad++; $display("FAIL single_hdr got=%h want=%h", obs2, {2'b00, 1'b0, 1'b0, 32'h0}); end
        step(1'b1, 32'h0000_0011);
        total++;
        if (obs2 !== {2'b01, 1'b0, 1'b0, 32'h11}) begin bad++; $display("FAIL single_w0 got=%h want=%h", obs2, {2'b01, 1'b0, 1'b0, 32'h11}); end
        step(1'b1, 32'h0000_0022);
        total++;
        if (obs2 !== {2'b01, 1'b1, 1'b0, 32'h22}) begin bad++; $display("FAIL single_w1 got=%h want=%h", obs2, {2'b01, 1'b1, 1'b0, 32'h22}); end
        step(1'b0, 32'h0);
        total++;
        if (obs2 !== {2'b00, 1'b0, 1'b0, 32'h22}) begin bad++; $display("FAIL single_hold got=%h want=%h", obs2, {2'b00, 1'b0, 1'b0, 32'h22}); end
    endtask

    task automatic test_interleave();
        step(1'b1, 32'hC000_0001);
        total++;
        if (obs2 !== {2'b00, 1'b0, 1'b0, 32'h22}) begin bad++; $display("FAIL il_hdr1 got=%h want=%h", obs2, {2'b00, 1'b0, 1'b0, 32'h22}); end
        step(1'b0, 32'h0);
        step(1'b1, 32'hFFFF_FFFF);
        total++;
        if (obs2 !== {2'b10, 1'b1, 1'b0, 32'hFFFF_FFFF}) begin bad++; $display("FAIL il_ch1 got=%h want=%h", obs2, {2'b10, 1'b1, 1'b0, 32'hFFFF_FFFF}); end
        step(1'b0, 32'h0);
        total++;
        if (obs2 !== {2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF}) begin bad++; $display("FAIL il_gap got=%h want=%h", obs2, {2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF}); end
        step(1'b1, 32'h8000_0001);
        step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0005);
        total++;
        if (obs2 !== {2'b01, 1'b1, 1'b0, 32'h5}) begin bad++; $display("FAIL il_ch0 got=%h want=%h", obs2, {2'b01, 1'b1, 1'b0, 32'h5}); end
    endtask

    task automatic test_malformed();
        step(1'b1, 32'h0000_0007);
        total++;
        if (obs2 !== {2'b00, 1'b0, 1'b1, 32'h5}) begin bad++; $display("FAIL mal_nohdr got=%h want=%h", obs2, {2'b00, 1'b0, 1'b1, 32'h5}); end
        step(1'b1, 32'h8000_0000);
        total++;
        if (obs2 !== {2'b00, 1'b0, 1'b1, 32'h5}) begin bad++; $display("FAIL mal_len0 got=%h want=%h", obs2, {2'b00, 1'b0, 1'b1, 32'h5}); end
        step(1'b1, 32'h8000_0001);
        total++;
        if (obs2 !== {2'b00, 1'b0, 1'b0, 32'h5}) begin bad++; $display("FAIL mal_hdr got=%h want=%h", obs2, {2'b00, 1'b0, 1'b0, 32'h5}); end
        step(1'b1, 32'h0000_000A);
        total++;
        if (obs2 !== {2'b01, 1'b1, 1'b0, 32'hA}) begin bad++; $display("FAIL mal_follow got=%h want=%h", obs2, {2'b01, 1'b1, 1'b0, 32'hA}); end
    endtask

    task automatic test_invalid_id();
        step3(1'b1, 32'hE000_0002);
        total++;
        if (obs3 !== {3'b000, 1'b0, 1'b1, 32'h0}) begin bad++; $display("FAIL bad_id_hdr got=%h want=%h", obs3, {3'b000, 1'b0, 1'b1, 32'h0}); end
        step3(1'b1, 32'h0000_0111);
        total++;
        if (obs3 !== {3'b000, 1'b0, 1'b0, 32'h0}) begin bad++; $display("FAIL bad_id_d0 got=%h want=%h", obs3, {3'b000, 1'b0, 1'b0, 32'h0}); end
        step3(1'b1, 32'h8000_0222);
        total++;
        if (obs3 !== {3'b000, 1'b0, 1'b0, 32'h0}) begin bad++; $display("FAIL bad_id_d1 got=%h want=%h", obs3, {3'b000, 1'b0, 1'b0, 32'h0}); end
        step3(1'b1, 32'hC000_0001);
        total++;
        if (obs3 !== {3'b000, 1'b0, 1'b0, 32'h0}) begin bad++; $display("FAIL bad_id_next got=%h want=%h", obs3, {3'b000, 1'b0, 1'b0, 32'h0}); end
        step3(1'b1, 32'h0000_0033);
        total++;
        if (obs3 !== {3'b100, 1'b1, 1'b0, 32'h33}) begin bad++; $display("FAIL bad_id_ch2 got=%h want=%h", obs3, {3'b100, 1'b1, 1'b0, 32'h33}); end
    endtask

    task automatic test_max_len();
        logic [35:0] exp;
        step(1'b1, 32'hC000_00FF);
        total++;
        if (obs2 !== {2'b00, 1'b0, 1'b0, 32'hA}) begin bad++; $display("FAIL max_hdr got=%h want=%h", obs2, {2'b00, 1'b0, 1'b0, 32'hA}); end
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 32'(i));
            exp = {2'b10, (i == 254), 1'b0, 32'(i)};
            total++;
            if (obs2 !== exp) begin bad++; $display("FAIL max_w%0d got=%h want=%h", i, obs2, exp); end
        end
        // Header immediately after the final word: must be taken as a header.
        step(1'b1, 32'h8000_0001);
        total++;
        if (obs2 !== {2'b00, 1'b0, 1'b0, 32'hFE}) begin bad++; $display("FAIL max_b2b_hdr got=%h want=%h", obs2, {2'b00, 1'b0, 1'b0, 32'hFE}); end
        step(1'b1, 32'h0000_0077);
        total++;
        if (obs2 !== {2'b01, 1'b1, 1'b0, 32'h77}) begin bad++; $display("FAIL max_b2b_w got=%h want=%h", obs2, {2'b01, 1'b1, 1'b0, 32'h77}); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 32'h8000_0004);
        step(1'b1, 32'h0000_0009);
        total++;
        if (obs2 !== {2'b01, 1'b0, 1'b0, 32'h9}) begin bad++; $display("FAIL rm_w0 got=%h want=%h", obs2, {2'b01, 1'b0, 1'b0, 32'h9}); end
        // Assert reset mid-cycle while the strobe is still high.
        #1;
        rst_n    = 1'b0;
        b2.in_nd = 1'b0;
        #1;
        obs2 = {b2.out_nd, b2.out_last, b2.error, b2.out_data};
        total++;
        if (obs2 !== 36'h0) begin bad++; $display("FAIL rm_async got=%h want=%h", obs2, 36'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h8000_0001);
        total++;
        if (obs2 !== {2'b00, 1'b0, 1'b0, 32'h0}) begin bad++; $display("FAIL rm_hdr got=%h want=%h", obs2, {2'b00, 1'b0, 1'b0, 32'h0}); end
        step(1'b1, 32'h0000_0003);
        total++;
        if (obs2 !== {2'b01, 1'b1, 1'b0, 32'h3}) begin bad++; $display("FAIL rm_follow got=%h want=%h", obs2, {2'b01, 1'b1, 1'b0, 32'h3}); end
        step(1'b0, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_interleave();
        test_malformed();
        test_invalid_id();
        test_max_len();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
